id_queue: RTL
=============

// Module: id_queue
// PURPOSE
//  Decoded-instruction queue between the decoder and the issue stage (is_stage).
//  Accepts up to two decoded uops per cycle from the decoder and presents the two
//  oldest entries as slot0/slot1. The issue stage consumes them with num_read
//  (00 none, 01 one, 11 two) in the same cycle. Absorbs decoder/issue rate mismatch.
// PARAMETERS
//  DEPTH    8   entries; power of two, >=4
//  ENTRY_W  200 packed entry {unknown,pc_next,pc,badv,exception,imm,rd,rk,rj,uop}
// PORTS
//  clk        in   1        clock
//  rstn       in   1        asynchronous active-low reset
//  flush      in   1        sync discard of all contents (pipeline redirect)
//  in_valid   in   2        decoder push: 00 none, 01 in_data0 only, 11 both; 10 illegal
//  in_data0   in   ENTRY_W  older pushed entry
//  in_data1   in   ENTRY_W  younger pushed entry
//  in_ready   out  1        >=2 free entries this cycle; push accepted only if set
//  out_data0  out  ENTRY_W  oldest entry, or all-zero (empty uop) if none
//  out_data1  out  ENTRY_W  second-oldest entry, or all-zero if none
//  num_read   in   2        issue pop: 00/01/11 as above; 10 treated as 00
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - State: rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap mod DEPTH), count register.
//    Async reset clears all three; storage array not reset (masked by count).
//  - Reset outputs: in_ready=1, count=0, out_data0=out_data1=0.
//  - in_ready = (DEPTH-count)>=2, from registered count only (no pop lookahead).
//  - push_n = in_ready ? {0,1,2 for in_valid 00,01,11} : 0; in_valid=10 -> 0.
//    in_data0 written at wr_ptr, in_data1 at wr_ptr+1 (mod DEPTH).
//  - pop_n = min(num_read count, count); over-read (11 with count==1) pops 1,
//    read of empty queue pops 0; never underflows.
//  - out_data0 = count>=1 ? mem[rd_ptr] : 0; out_data1 = count>=2 ? mem[rd_ptr+1] : 0.
//    Zero entry has UOP_NEMPTY=0 and exception=0, so issue sees it as nop.
//  - Next-state: rd_ptr+=pop_n, wr_ptr+=push_n, count+=push_n-pop_n; push and
//    pop in the same cycle both take effect; count never exceeds DEPTH.
//  - Latency (no bypass): pushed entry visible at out_data* the cycle after push.
//  - flush: highest priority; next cycle count=0, rd_ptr=wr_ptr=0; same-cycle
//    push and pop ignored. Async reset overrides flush at any time.
//  - Order strictly preserved; in_data0 always older than in_data1.
// CONFIGURATION
//  ID_QUEUE_BYPASS_EN defined:
//   - When count==0 and not flush, out_data0/1 driven directly by in_data0/1
//     (masked to 0 per in_valid), ignoring in_ready (empty => ready).
//   - Bypassed entries popped by num_read this cycle are not written; only the
//     unpopped remainder is written at wr_ptr. Zero-cycle latency through an
//     empty queue.
//   - With count>=1 behaviour identical to non-bypass build.
//  Not defined: no in->out combinational path; 1-cycle minimum latency.
// TESTING
//  - Reset: rstn=0 mid-run with count=5 -> count=0, in_ready=1, outputs 0 at once.
//  - Fill: in_valid=11 each cycle, num_read=00, DEPTH=8 -> count 2,4,6,8; in_ready=0
//    at count 7/8; further pushes dropped; drain gives A0..A7 in order.
//  - Over-read: count=1 (entry X), num_read=11 -> out_data0=X, out_data1=0; next count=0.
//  - Simultaneous: count=3, in_valid=11, num_read=01 -> next count=4; order kept
//    across rd/wr pointer wrap (start rd_ptr=6).
//  - Flush: count=6, flush=1 with in_valid=11, num_read=11 -> next count=0, outputs 0.
//  - Bypass (ID_QUEUE_BYPASS_EN): empty, in_valid=11 {B0,B1}, num_read=01 ->
//    out_data0=B0 same cycle; next cycle count=1, out_data0=B1. Without macro:
//    out_data0=0 that cycle, count=2 next.

Source files
------------

// File: rtl/id_queue.sv
// Decoded-instruction queue between decoder and issue stage.
// Accepts up to two uops per cycle and presents the two oldest entries as
// out_data0/out_data1; issue pops zero, one or two of them in the same cycle.
// Optional build macro: ID_QUEUE_BYPASS_EN (zero-latency path through an empty queue).
module id_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRY_W = 200
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [ENTRY_W-1:0]     in_data0,
  input  logic [ENTRY_W-1:0]     in_data1,
  output logic                   in_ready,
  output logic [ENTRY_W-1:0]     out_data0,
  output logic [ENTRY_W-1:0]     out_data1,
  input  logic [1:0]             num_read,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_p1, wr_ptr_p1;
  logic [CntW-1:0]    count_q, count_d;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [1:0]         in_n;     // entries offered by the decoder
  logic [1:0]         rd_req;   // entries requested by issue
  logic [1:0]         pop_n;    // entries actually consumed
  logic [1:0]         push_n;   // entries actually written to storage
  logic [1:0]         rd_adv;   // read-pointer advance (stored entries consumed)
  logic               bypass;
  logic               we0, we1;
  logic [ENTRY_W-1:0] wdata0;

  assign rd_ptr_p1 = rd_ptr_q + PtrW'(1);
  assign wr_ptr_p1 = wr_ptr_q + PtrW'(1);
  assign count     = count_q;

  // Ready only on registered occupancy, so the decoder never depends on issue timing.
  assign in_ready  = (count_q <= CntW'(DEPTH - 2));

  // Decode requests, select output source and compute push/pop amounts.
  always_comb begin
    in_n = 2'd0;
    if (in_valid == 2'b01) begin
      in_n = 2'd1;
    end else if (in_valid == 2'b11) begin
      in_n = 2'd2;
    end

    rd_req = 2'd0;
    if (num_read == 2'b01) begin
      rd_req = 2'd1;
    end else if (num_read == 2'b11) begin
      rd_req = 2'd2;
    end

    bypass = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
    bypass = (count_q == '0) && !flush;
`endif

    out_data0 = '0;
    out_data1 = '0;
    wdata0    = in_data0;
    if (bypass) begin
      if (in_n >= 2'd1) out_data0 = in_data0;
      if (in_n == 2'd2) out_data1 = in_data1;
      // Consumed bypass entries never touch storage; the remainder is written in order.
      pop_n  = (rd_req < in_n) ? rd_req : in_n;
      push_n = in_n - pop_n;
      rd_adv = 2'd0;
      if (pop_n == 2'd1) wdata0 = in_data1;
    end else begin
      if (count_q >= CntW'(1)) out_data0 = mem[rd_ptr_q];
      if (count_q >= CntW'(2)) out_data1 = mem[rd_ptr_p1];
      // Clamp to occupancy so an over-read or empty read never underflows.
      pop_n  = (CntW'(rd_req) <= count_q) ? rd_req : count_q[1:0];
      push_n = in_ready ? in_n : 2'd0;
      rd_adv = pop_n;
    end

    we0 = !flush && (push_n >= 2'd1);
    we1 = !flush && (push_n == 2'd2);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PtrW'(rd_adv);
      wr_ptr_d = wr_ptr_q + PtrW'(push_n);
      count_d  = count_q + CntW'(push_n) - CntW'(rd_adv);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents outside the occupied window are masked by count.
  always_ff @(posedge clk) begin
    if (we0) mem[wr_ptr_q]  <= wdata0;
    if (we1) mem[wr_ptr_p1] <= in_data1;
  end

endmodule
